load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/riscv_pkg.sv | 61 ++++++
 rtl/lsu_align.sv | 49 ++++
 rtl/load_store_unit.sv | 156 +++++++++++++++
 tb/tb_load_store_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Purpose: shared load/store op encodings, LSU FSM states and helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package riscv_pkg;

    localparam int LSU_RD_W = 6;
    localparam int WB_W     = LSU_RD_W + 32;

    // {is_store, funct3}
    typedef enum logic [3:0] {
        LSU_LB  = 4'b0000,
        LSU_LH  = 4'b0001,
        LSU_LW  = 4'b0010,
        LSU_LBU = 4'b0100,
        LSU_LHU = 4'b0101,
        LSU_SB  = 4'b1000,
        LSU_SH  = 4'b1001,
        LSU_SW  = 4'b1010
    } lsu_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        RESP   = 2'd3
    } lsu_state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Access size from funct3; funct3[1] set means word, otherwise funct3[0] picks byte/half.
    function automatic logic [1:0] lsu_size(input logic [2:0] funct3);
        return funct3[1] ? SZ_W : {1'b0, funct3[0]};
    endfunction

    // True when the byte offset does not match the natural alignment of the access.
    function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (lsu_size(funct3))
            SZ_H:    mis = off[0];
            SZ_W:    mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Round a byte address down to the natural alignment of the access.
    function automatic logic [31:0] lsu_align_addr(input logic [2:0] funct3, input logic [31:0] addr);
        logic [31:0] a;
        a = addr;
        case (lsu_size(funct3))
            SZ_H:    a = {addr[31:1], 1'b0};
            SZ_W:    a = {addr[31:2], 2'b00};
            default: a = addr;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Purpose: byte-lane steering: store byte enables / replicated data, load extract + extend.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] st_wdata,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed lane of the read word.
    always_comb begin
        byte_sel = rdata[{off, 3'b000} +: 8];
        half_sel = rdata[{off[1], 4'b0000} +: 16];
    end

    // Lane enables and replicated store data; sign/zero extension picked by funct3[2].
    always_comb begin
        be       = 4'b1111;
        st_wdata = wdata;
        ld_data  = rdata;
        case (lsu_size(funct3))
            SZ_B: begin
                be       = 4'b0001 << off;
                st_wdata = {4{wdata[7:0]}};
                ld_data  = funct3[2] ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            SZ_H: begin
                be       = 4'b0011 << off;
                st_wdata = {2{wdata[15:0]}};
                ld_data  = funct3[2] ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            default: begin
                be       = 4'b1111;
                st_wdata = wdata;
                ld_data  = rdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Purpose: single-outstanding load/store unit between decode and a gnt/rvalid memory port.
// Latency: load = handshake + 3 cycles minimum (REQ, WAIT_R, RESP); store done on gnt.
// Backpressure: req_ready only in IDLE; mem_req held stable until mem_gnt; read timeout aborts.
// Option: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning down.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int RD_W    = LSU_RD_W
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [RD_W-1:0]   req_rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [29:0]       mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic [RD_W+31:0]  wb_reg,
    output logic              wb_valid,
    output logic [1:0]        lsu_err
);

    localparam int              CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    lsu_state_e       state;
    logic [2:0]       funct3_q;
    logic [1:0]       off_q;
    logic [RD_W-1:0]  rd_q;
    logic [CNT_W-1:0] wait_cnt;

    logic [31:0]      req_addr_al;
    logic             trap;
    logic [2:0]       al_funct3;
    logic [1:0]       al_off;
    logic [3:0]       al_be;
    logic [31:0]      al_wdata;
    logic [31:0]      al_ldata;

    // Misalignment handling of the incoming request: trap it, or round the address down.
    always_comb begin
        trap        = 1'b0;
        req_addr_al = req_addr;
`ifdef LSU_MISALIGN_TRAP_EN
        trap        = lsu_misaligned(req_op[2:0], req_addr[1:0]);
`else
        req_addr_al = lsu_align_addr(req_op[2:0], req_addr);
`endif
    end

    // One aligner serves both directions: store lanes at accept time, load extract afterwards.
    always_comb begin
        al_funct3 = (state == IDLE) ? req_op[2:0]       : funct3_q;
        al_off    = (state == IDLE) ? req_addr_al[1:0]  : off_q;
    end

    lsu_align u_align (
        .funct3   (al_funct3),
        .off      (al_off),
        .wdata    (req_wdata),
        .rdata    (mem_rdata),
        .be       (al_be),
        .st_wdata (al_wdata),
        .ld_data  (al_ldata)
    );

    // Transaction FSM with registered outputs; async reset discards any transaction in flight.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            wb_reg    <= '0;
            wb_valid  <= 1'b0;
            lsu_err   <= '0;
            funct3_q  <= '0;
            off_q     <= '0;
            rd_q      <= '0;
            wait_cnt  <= '0;
        end else begin
            wb_valid <= 1'b0;
            lsu_err  <= '0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        funct3_q <= req_op[2:0];
                        off_q    <= req_addr_al[1:0];
                        rd_q     <= req_rd;
                        if (trap) begin
                            // Misaligned access never reaches memory; stay ready.
                            lsu_err[0] <= 1'b1;
                        end else begin
                            state     <= REQ;
                            req_ready <= 1'b0;
                            mem_req   <= 1'b1;
                            mem_we    <= req_op[3];
                            mem_addr  <= req_addr_al[31:2];
                            mem_be    <= al_be;
                            mem_wdata <= al_wdata;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (mem_we) begin
                            state     <= IDLE;
                            req_ready <= 1'b1;
                        end else begin
                            state    <= WAIT_R;
                            wait_cnt <= CNT_W'(1);
                        end
                    end
                end
                WAIT_R: begin
                    // Data wins over timeout when both land in the same cycle.
                    if (mem_rvalid) begin
                        wb_reg   <= {rd_q, al_ldata};
                        wb_valid <= 1'b1;
                        state    <= RESP;
                        wait_cnt <= '0;
                    end else if (wait_cnt == TIMEOUT_C) begin
                        lsu_err[1] <= 1'b1;
                        state      <= IDLE;
                        req_ready  <= 1'b1;
                        wait_cnt   <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Purpose: directed self-checking bench for load_store_unit (vector table + corner sequences).
// Latency: checks the handshake + 3 load latency and the 16-cycle read timeout.
// Backpressure: exercises delayed mem_gnt, missing mem_rvalid and reset mid-transaction.
module tb_load_store_unit;

    logic        i_clk;
    logic        i_rstn;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [5:0]  req_rd;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [37:0] wb_reg;
    logic        wb_valid;
    logic [1:0]  lsu_err;

    int n_cmp = 0;
    int n_err = 0;

    load_store_unit #(.TIMEOUT(16), .RD_W(6)) dut (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .wb_reg     (wb_reg),
        .wb_valid   (wb_valid),
        .lsu_err    (lsu_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    localparam logic [3:0] OP_LB = 4'b0000, OP_LH = 4'b0001, OP_LW = 4'b0010,
                           OP_LBU = 4'b0100, OP_LHU = 4'b0101,
                           OP_SB = 4'b1000, OP_SH = 4'b1001, OP_SW = 4'b1010;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [5:0]  rd;
        logic [31:0] rdata;
        logic [29:0] exp_maddr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_ld;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Present one request for one cycle; returns just after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [5:0] rd);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_rd    = rd;
        step();
        req_valid = 1'b0;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        chk($sformatf("vec%0d_ready", i), 64'(req_ready), 64'd1);
        issue(v.op, v.addr, v.wdata, v.rd);
        chk($sformatf("vec%0d_mem_req", i), 64'(mem_req), 64'd1);
        chk($sformatf("vec%0d_we", i), 64'(mem_we), 64'(v.op[3]));
        chk($sformatf("vec%0d_maddr", i), 64'(mem_addr), 64'(v.exp_maddr));
        chk($sformatf("vec%0d_be", i), 64'(mem_be), 64'(v.exp_be));
        if (v.op[3]) chk($sformatf("vec%0d_wdata", i), 64'(mem_wdata), 64'(v.exp_wdata));
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk($sformatf("vec%0d_req_drop", i), 64'(mem_req), 64'd0);
        chk($sformatf("vec%0d_wb_early", i), 64'(wb_valid), 64'd0);
        if (!v.op[3]) begin
            mem_rvalid = 1'b1;
            mem_rdata  = v.rdata;
            step();
            mem_rvalid = 1'b0;
            chk($sformatf("vec%0d_wb_valid", i), 64'(wb_valid), 64'd1);
            chk($sformatf("vec%0d_wb_reg", i), 64'(wb_reg), 64'({v.rd, v.exp_ld}));
            chk($sformatf("vec%0d_busy", i), 64'(req_ready), 64'd0);
            step();
            chk($sformatf("vec%0d_wb_pulse", i), 64'(wb_valid), 64'd0);
        end
        chk($sformatf("vec%0d_ready_back", i), 64'(req_ready), 64'd1);
    endtask

    initial begin
        req_valid = 0; req_op = 0; req_addr = 0; req_wdata = 0; req_rd = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;

        //            op      addr          wdata          rd     rdata          maddr    be       wdata_lanes    load result
        vecs[0] = '{OP_LW,  32'h100, 32'h0,          6'd5,  32'hDEADBEEF, 30'h40, 4'b1111, 32'h0,         32'hDEADBEEF};
        vecs[1] = '{OP_LB,  32'h103, 32'h0,          6'd1,  32'h80FF0000, 30'h40, 4'b1000, 32'h0,         32'hFFFFFF80};
        vecs[2] = '{OP_LBU, 32'h103, 32'h0,          6'd2,  32'h80FF0000, 30'h40, 4'b1000, 32'h0,         32'h00000080};
        vecs[3] = '{OP_LH,  32'h102, 32'h0,          6'd3,  32'h80FF0000, 30'h40, 4'b1100, 32'h0,         32'hFFFF80FF};
        vecs[4] = '{OP_LHU, 32'h100, 32'h0,          6'd4,  32'h1234F00D, 30'h40, 4'b0011, 32'h0,         32'h0000F00D};
        vecs[5] = '{OP_LB,  32'h101, 32'h0,          6'd6,  32'h00007F00, 30'h40, 4'b0010, 32'h0,         32'h0000007F};
        vecs[6] = '{OP_SB,  32'h201, 32'h000000AB,   6'd0,  32'h0,        30'h80, 4'b0010, 32'hABABABAB,  32'h0};
        vecs[7] = '{OP_SW,  32'h204, 32'hCAFEBABE,   6'd0,  32'h0,        30'h81, 4'b1111, 32'hCAFEBABE,  32'h0};
        vecs[8] = '{OP_SH,  32'h200, 32'hFFFF5678,   6'd0,  32'h0,        30'h80, 4'b0011, 32'h56785678,  32'h0};
        vecs[9] = '{OP_LH,  32'h0FE, 32'h0,          6'd63, 32'h80010000, 30'h3F, 4'b1100, 32'h0,         32'hFFFF8001};

        // Reset state
        i_rstn = 1'b0;
        step();
        step();
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_be", 64'(mem_be), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_wb_reg", 64'(wb_reg), 64'd0);
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_lsu_err", 64'(lsu_err), 64'd0);
        i_rstn = 1'b1;
        step();
        chk("rst_ready", 64'(req_ready), 64'd1);

        // Table of single transactions with immediate gnt / rvalid
        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Read timeout: rvalid never comes; wb_reg keeps the last load (vec9)
        issue(OP_LW, 32'h300, 32'h0, 6'd7);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("to_err_c%0d", k), 64'(lsu_err), (k == 16) ? 64'd2 : 64'd0);
        end
        chk("to_ready", 64'(req_ready), 64'd1);
        chk("to_wb_valid", 64'(wb_valid), 64'd0);
        chk("to_wb_keep", 64'(wb_reg), 64'({6'd63, 32'hFFFF8001}));
        step();
        chk("to_err_pulse", 64'(lsu_err), 64'd0);

        // rvalid in the 16th WAIT_R cycle: data wins, no error
        issue(OP_LW, 32'h304, 32'h0, 6'd9);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        for (int k = 1; k < 16; k++) step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0BADF00D;
        step();
        mem_rvalid = 1'b0;
        chk("edge_wb_valid", 64'(wb_valid), 64'd1);
        chk("edge_err", 64'(lsu_err), 64'd0);
        chk("edge_wb_reg", 64'(wb_reg), 64'({6'd9, 32'h0BADF00D}));
        step();

        // Store with gnt delayed 4 cycles; stray rvalid during REQ is ignored
        issue(OP_SH, 32'h202, 32'h00001234, 6'd0);
        for (int c = 1; c <= 5; c++) begin
            mem_rvalid = (c == 2);
            mem_gnt    = (c == 5);
            chk($sformatf("sh_req_c%0d", c), 64'(mem_req), 64'd1);
            chk($sformatf("sh_be_c%0d", c), 64'(mem_be), 64'(4'b1100));
            chk($sformatf("sh_wdata_c%0d", c), 64'(mem_wdata), 64'(32'h12341234));
            chk($sformatf("sh_addr_c%0d", c), 64'(mem_addr), 64'(30'h80));
            chk($sformatf("sh_wb_c%0d", c), 64'(wb_valid), 64'd0);
            step();
        end
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        chk("sh_done_req", 64'(mem_req), 64'd0);
        chk("sh_done_ready", 64'(req_ready), 64'd1);
        chk("sh_done_wb", 64'(wb_valid), 64'd0);
        step();
        chk("sh_after_wb", 64'(wb_valid), 64'd0);

        // Misaligned word load at 0x101
`ifdef LSU_MISALIGN_TRAP_EN
        issue(OP_LW, 32'h101, 32'h0, 6'd3);
        chk("mis_err", 64'(lsu_err), 64'd1);
        chk("mis_no_req", 64'(mem_req), 64'd0);
        chk("mis_ready", 64'(req_ready), 64'd1);
        step();
        chk("mis_err_pulse", 64'(lsu_err), 64'd0);
        chk("mis_no_req2", 64'(mem_req), 64'd0);
`else
        issue(OP_LW, 32'h101, 32'h0, 6'd3);
        chk("mis_req", 64'(mem_req), 64'd1);
        chk("mis_maddr", 64'(mem_addr), 64'(30'h40));
        chk("mis_be", 64'(mem_be), 64'(4'b1111));
        chk("mis_err", 64'(lsu_err), 64'd0);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h11223344;
        step();
        mem_rvalid = 1'b0;
        chk("mis_wb", 64'(wb_reg), 64'({6'd3, 32'h11223344}));
        step();
`endif

        // Reset during REQ drops mem_req without waiting for a clock edge
        issue(OP_LW, 32'h400, 32'h0, 6'd2);
        chk("rreq_req", 64'(mem_req), 64'd1);
        #2;
        i_rstn = 1'b0;
        #1;
        chk("rreq_async_drop", 64'(mem_req), 64'd0);
        chk("rreq_wb_clear", 64'(wb_reg), 64'd0);
        @(posedge i_clk);
        #1;
        i_rstn = 1'b1;
        step();
        chk("rreq_ready", 64'(req_ready), 64'd1);
        chk("rreq_req_idle", 64'(mem_req), 64'd0);

        // Reset during WAIT_R: later rvalid must not produce a write-back
        issue(OP_LW, 32'h500, 32'h0, 6'd4);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        #2;
        i_rstn = 1'b0;
        #1;
        chk("rwait_req", 64'(mem_req), 64'd0);
        chk("rwait_wb", 64'(wb_valid), 64'd0);
        @(posedge i_clk);
        #1;
        i_rstn = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFFFFFF;
        step();
        chk("rwait_ign1", 64'(wb_valid), 64'd0);
        step();
        mem_rvalid = 1'b0;
        chk("rwait_ign2", 64'(wb_valid), 64'd0);
        chk("rwait_wb_reg", 64'(wb_reg), 64'd0);
        chk("rwait_ready", 64'(req_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
